// File: rtl/crossbar_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// crossbar_ctrl_sequencer
//
// Initiator for the crossbar configuration port. A small table of routing
// words, each with a dwell time, is loaded through cfg_msg/cfg_val/cfg_rdy.
// A start strobe issues the table in order, one word per control handshake,
// waiting the entry's dwell time after each handshake and optionally looping.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   cfg_msg         {hold[HOLD_WIDTH-1:0], word[CONTROL_BIT_WIDTH-1:0]}
//   cfg_val/cfg_rdy table-write handshake (accepted only in IDLE)
//   clear           empty the table (IDLE only, highest priority)
//   start           single-cycle strobe to begin issuing the table
//   loop            restart from entry 0 after the last entry while high
//   control         registered control word to the crossbar
//   control_val     control word valid
//   control_rdy     crossbar ready for control word
//   busy            high whenever the sequencer is not IDLE
//   done            one-cycle pulse when a non-looping pass completes
// ---------------------------------------------------------------------------
module crossbar_ctrl_sequencer #(
   parameter int CONTROL_BIT_WIDTH = 42,
   parameter int DEPTH             = 8,
   parameter int HOLD_WIDTH        = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [HOLD_WIDTH+CONTROL_BIT_WIDTH-1:0] cfg_msg,
   input  logic                                 cfg_val,
   output logic                                 cfg_rdy,
   input  logic                                 clear,
   input  logic                                 start,
   input  logic                                 loop,
   output logic [CONTROL_BIT_WIDTH-1:0]         control,
   output logic                                 control_val,
   input  logic                                 control_rdy,
   output logic                                 busy,
   output logic                                 done
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam int MSG_W = HOLD_WIDTH + CONTROL_BIT_WIDTH;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic [MSG_W-1:0]             table_q [DEPTH];
   logic [1:0]                   state_q, state_d;
   logic [CNT_W-1:0]             count_q, count_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [HOLD_WIDTH-1:0]        hold_cnt_q, hold_cnt_d;
   logic [CONTROL_BIT_WIDTH-1:0] control_q, control_d;
   logic                         control_val_q, control_val_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;

   logic                         wr_en_s;
   logic                         advance_s;
   logic                         is_last_s;
   logic [IDX_W-1:0]             idx_inc_s;
   logic [HOLD_WIDTH-1:0]        cur_hold_s;

   // Gated by reset so the port reads not-ready while reset is held.
   assign cfg_rdy    = !reset && (state_q == ST_IDLE) && (count_q < DEPTH_C)
                       && !start && !clear;
   assign wr_en_s    = cfg_val && cfg_rdy;
   assign idx_inc_s  = idx_q + IDX_W'(1);
   assign cur_hold_s = table_q[idx_q][MSG_W-1:CONTROL_BIT_WIDTH];
   // idx+1 >= count means idx is the last valid entry.
   assign is_last_s  = ({1'b0, idx_q} + CNT_W'(1)) >= count_q;

   assign control     = control_q;
   assign control_val = control_val_q;
   assign busy        = busy_q;
   assign done        = done_q;

   // Table storage: written only through the cfg handshake, no reset needed.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         table_q[count_q[IDX_W-1:0]] <= cfg_msg;
      end
   end

   // Next-state and next-output computation for the issue sequencer.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      idx_d         = idx_q;
      hold_cnt_d    = hold_cnt_q;
      control_d     = control_q;
      control_val_d = control_val_q;
      done_d        = 1'b0;
      advance_s     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               count_d = '0;
            end else if (start && (count_q != '0)) begin
               state_d       = ST_ISSUE;
               idx_d         = '0;
               control_d     = table_q[{IDX_W{1'b0}}][CONTROL_BIT_WIDTH-1:0];
               control_val_d = 1'b1;
            end else if (wr_en_s) begin
               count_d = count_q + CNT_W'(1);
            end else begin
               count_d = count_q;
            end
         end
         ST_ISSUE: begin
            if (control_rdy) begin
               control_val_d = 1'b0;
               if (cur_hold_s != '0) begin
                  hold_cnt_d = cur_hold_s;
                  state_d    = ST_HOLD;
               end else begin
                  advance_s = 1'b1;
               end
            end else begin
               control_val_d = 1'b1;
            end
         end
         ST_HOLD: begin
            hold_cnt_d = hold_cnt_q - HOLD_WIDTH'(1);
            // Advancing on the count of 1 yields exactly 'hold' idle cycles.
            if (hold_cnt_q == HOLD_WIDTH'(1)) begin
               advance_s = 1'b1;
            end else begin
               advance_s = 1'b0;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            control_val_d = 1'b0;
         end
      endcase

      // Next-entry rule, shared by zero-hold handshakes and hold expiry.
      if (advance_s) begin
         if (!is_last_s) begin
            idx_d         = idx_inc_s;
            state_d       = ST_ISSUE;
            control_d     = table_q[idx_inc_s][CONTROL_BIT_WIDTH-1:0];
            control_val_d = 1'b1;
         end else if (loop) begin
            idx_d         = '0;
            state_d       = ST_ISSUE;
            control_d     = table_q[{IDX_W{1'b0}}][CONTROL_BIT_WIDTH-1:0];
            control_val_d = 1'b1;
         end else begin
            state_d       = ST_IDLE;
            control_val_d = 1'b0;
            done_d        = 1'b1;
         end
      end else begin
         done_d = done_d;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // Sequencer state and registered outputs; reset aborts any issue at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         count_q       <= '0;
         idx_q         <= '0;
         hold_cnt_q    <= '0;
         control_q     <= '0;
         control_val_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         idx_q         <= idx_d;
         hold_cnt_q    <= hold_cnt_d;
         control_q     <= control_d;
         control_val_q <= control_val_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

endmodule

// File: doc/crossbar_ctrl_sequencer.md
Name: crossbar_ctrl_sequencer

Overview:
- Initiator side of the crossbar control channel: drives control / control_val / control_rdy into the crossbar's configuration port.
- Holds a small table of routing configurations, each paired with a dwell time.
- On start, issues the table in order, one configuration per handshake, optionally looping.
- Lets the bench and top level reconfigure crossbar routing on a schedule instead of hand-driving the control word.

Parameters:
- CONTROL_BIT_WIDTH, 42, width of one crossbar control word.
- DEPTH, 8, number of table entries; power of two, minimum 2.
- HOLD_WIDTH, 16, width of the per-entry dwell counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- cfg_msg  input  HOLD_WIDTH+CONTROL_BIT_WIDTH  table entry: [HOLD_WIDTH+CONTROL_BIT_WIDTH-1:CONTROL_BIT_WIDTH] = hold cycles, [CONTROL_BIT_WIDTH-1:0] = control word.
- cfg_val  input  1  table-write valid.
- cfg_rdy  output  1  table-write ready.
- clear  input  1  empty the table (IDLE only).
- start  input  1  begin issuing the table (single-cycle strobe).
- loop  input  1  when high, restart from entry 0 after the last entry.
- control  output  CONTROL_BIT_WIDTH  control word to crossbar.
- control_val  output  1  control word valid.
- control_rdy  input  1  crossbar ready for control word.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a non-looping pass completes.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-high.
  - While reset is high: state=IDLE, count=0, idx=0, hold_cnt=0, control=0, control_val=0, busy=0, done=0, cfg_rdy=0.
  - Reset mid-issue aborts immediately; no handshake may complete on the reset edge.
- Table storage:
  - DEPTH x (HOLD_WIDTH+CONTROL_BIT_WIDTH) register array.
  - count ranges 0..DEPTH and needs clog2(DEPTH)+1 bits.
- Table write:
  - cfg_rdy = (state==IDLE) && (count<DEPTH) && !start && !clear.
  - On cfg_val && cfg_rdy: entry[count] <= cfg_msg, count++.
  - When count==DEPTH, cfg_rdy=0 and the write is not accepted; nothing is overwritten.
- Clear: in IDLE, clear sets count=0. It has priority over start and cfg writes. clear is ignored outside IDLE.
- FSM states: IDLE, ISSUE, HOLD.
- IDLE:
  - start && count>0 && !clear -> ISSUE, idx=0.
  - start with count==0 is ignored (no done pulse).
- ISSUE:
  - control_val=1. control = entry[idx].word is registered, loaded on entry to ISSUE.
  - control and control_val stay stable until control_rdy is sampled high.
  - On handshake: control_val<=0.
    - If entry[idx].hold > 0: hold_cnt<=hold, go to HOLD.
    - If hold == 0: advance immediately (next-entry rule).
- HOLD:
  - hold_cnt decrements every cycle.
  - When hold_cnt==1 at the edge, advance. Hold H therefore gives exactly H cycles with control_val=0 between handshake and next ISSUE.
- Next-entry rule:
  - If idx < count-1: idx++, go to ISSUE.
  - Else if loop is high (sampled at this edge): idx=0, go to ISSUE.
  - Else: go to IDLE and pulse done=1 for one cycle.
- Latency:
  - start sampled at edge t -> control_val=1 during cycle t+1.
  - Handshake at edge t with hold=0 -> next control_val=1 during cycle t+1, i.e. back-to-back issue with no bubble.
- Priority and ignored inputs:
  - start during busy is ignored.
  - cfg_val during busy is not accepted (cfg_rdy=0).
  - Deasserting loop mid-pass ends the run after the current last entry.
- busy is registered and equals (state != IDLE).
- control retains its last issued value in IDLE; it is cleared only by reset.

Test Plan:
- Reset then write 3 entries {hold=0, word=A}, {hold=0, word=B}, {hold=0, word=C}; start; control_rdy tied 1 -> control_val high 3 consecutive cycles starting the cycle after start, carrying A, B, C; done pulses on the cycle after C's handshake; busy low afterwards.
- Entry {hold=4, word=0x155}; start; control_rdy=1 -> one handshake, then exactly 4 cycles of control_val=0, then done; no second issue.
- control_rdy held 0 for 5 cycles after start -> control_val=1 and control stable at entry 0 for all 5 cycles; handshake occurs on the first cycle control_rdy=1.
- Write DEPTH=8 entries, then present a 9th with cfg_val=1 -> cfg_rdy=0, count stays 8, entry 0 unchanged. Then clear -> count=0, and a subsequent start is ignored (busy stays 0, no done).
- loop=1 with 2 entries (hold=0), control_rdy=1 -> pattern A, B, A, B… repeats. Drop loop during an A issue -> run finishes after the following B with a single done pulse.
- Assert reset during HOLD and during ISSUE with control_rdy=0 -> control_val, busy, and done drop immediately; count=0; after release, cfg_rdy=1 and a fresh table write and start work normally.
